fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Fetch-stage next-PC generator that sits directly upstream of the branch predictor. It owns the PC_F register and drives the predictor's read address.
- Consumes the predictor's hit/target in F and carries the prediction into D alongside the instruction.
- Resolves the prediction against the decode-stage branch outcome, redirects fetch on a misprediction or exception, and generates the IF/ID flush.
- Keeps saturating branch and misprediction statistics counters.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- EXC_VECTOR, 32'h8000_0180, PC loaded on exception.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all registers update on posedge.
- rst  in  1  asynchronous, active-high reset.
- stall_f  in  1  hold PC_F.
- stall_d  in  1  hold the IF/ID stage; while high, there is no resolution and the F->D prediction pipe holds.
- exc_req  in  1  exception redirect request (single-cycle pulse).
- predictor_sel  in  1  predictor hit and predicted taken for pc_f.
- predictor_target  in  32  predicted target for pc_f.
- branch_d  in  1  instruction in D is a branch.
- branch_taken_d  in  1  resolved outcome of the branch in D.
- pc_branch_d  in  32  resolved branch target in D.
- cnt_clr  in  1  synchronous clear of the counters.
- pc_f  out  32  current fetch PC; feeds the predictor read port and IMEM.
- pc_plus4_f  out  32  pc_f + 4.
- flush_d  out  1  kill the instruction entering D at the next edge.
- mispredict  out  1  combinational misprediction detected in D this cycle.
- branch_cnt  out  CNT_W  resolved-branch count.
- mispred_cnt  out  CNT_W  misprediction count.

Behaviour:
- Reset (async, rst=1):
  - pc_f = RESET_VECTOR.
  - pred_d = 0; pred_target_d = 0; pc_plus4_d = RESET_VECTOR + 4.
  - Both counters = 0.
  - Combinational outputs follow from these values: flush_d = 0 and mispredict = 0 while exc_req = 0.
  - Deassertion mid-stream restarts fetch at RESET_VECTOR on the first edge after release.
- F->D pipe registers:
  - Update when stall_d = 0 or flush_d = 1: pred_d <= flush_d ? 0 : predictor_sel; pred_target_d <= predictor_target; pc_plus4_d <= pc_f + 4.
  - Hold otherwise.
- Resolution (only when stall_d = 0). Define resolve = branch_d & ~stall_d.
  - mis_nt = resolve & pred_d & ~branch_taken_d → redirect to pc_plus4_d.
  - mis_t = resolve & branch_taken_d & (~pred_d | pred_target_d != pc_branch_d) → redirect to pc_branch_d.
  - mis_alias = ~stall_d & ~branch_d & pred_d (predicted taken on a non-branch) → redirect to pc_plus4_d.
  - mispredict = mis_nt | mis_t | mis_alias.
- Next-PC priority, highest first:
  1. exc_req → EXC_VECTOR.
  2. mis_t → pc_branch_d.
  3. mis_nt or mis_alias → pc_plus4_d.
  4. stall_f → hold pc_f.
  5. predictor_sel → predictor_target.
  6. Otherwise pc_f + 4.
- Exception and redirect override stall_f.
- flush_d = exc_req | mispredict (combinational). The same edge that loads the redirect PC clears pred_d.
- Arithmetic:
  - PC adds are 32-bit, modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
  - No alignment check; bits [1:0] pass through unchanged.
- Counters:
  - branch_cnt += 1 on resolve; mispred_cnt += 1 on mispredict.
  - Both saturate at all-ones.
  - cnt_clr has priority over increment and forces 0.
- Simultaneous events:
  - exc_req with a misprediction: the exception wins the PC.
  - mispred_cnt still counts the misprediction; flush_d is 1.
- Latency:
  - Redirect PC is visible on pc_f one cycle after detection.
  - A correct taken prediction gives zero-bubble fetch of the target.

Test Plan:
- Reset then free run, stall_f = 0, predictor_sel = 0 → pc_f sequence 0x0, 0x4, 0x8, 0xC; flush_d = 0.
- Predictor hit at pc_f = 0x10, target 0x40; next cycle branch_d = 1, taken, pc_branch_d = 0x40 → pc_f 0x40 with no redirect; mispredict = 0; branch_cnt = 1.
- Predicted taken at 0x20 (target 0x80); in D, branch_taken_d = 0 → mispredict = 1, flush_d = 1, pc_f = 0x24 next cycle; mispred_cnt = 1.
- Not predicted at 0x30; in D, taken to 0x100 with stall_d = 1 for 2 cycles, then 0 → no redirect while stalled; on release, pc_f = 0x100 next cycle.
- exc_req together with mis_t (pc_branch_d = 0x200) while stall_f = 1 → pc_f = 0x8000_0180; flush_d = 1; mispred_cnt increments.
- Preload mispred_cnt to 0xFFFF via repeated mispredictions with CNT_W = 16 → the counter stays at 0xFFFF; cnt_clr asserted together with a mispredict → 0.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch-stage next-PC generator.
// Owns PC_F, carries the branch prediction from F into D, checks it against
// the decode-stage branch outcome, and redirects fetch on a misprediction or
// an exception. It also drives the IF/ID flush and keeps saturating counters
// for resolved branches and for mispredictions.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic             stall_d,
  input  logic             exc_req,
  input  logic             predictor_sel,
  input  logic [31:0]      predictor_target,
  input  logic             branch_d,
  input  logic             branch_taken_d,
  input  logic [31:0]      pc_branch_d,
  input  logic             cnt_clr,
  output logic [31:0]      pc_f,
  output logic [31:0]      pc_plus4_f,
  output logic             flush_d,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic [31:0]      r_pc_f;
  logic             r_pred_d;
  logic [31:0]      r_pred_target_d;
  logic [31:0]      r_pc_plus4_d;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  logic [31:0] w_pc_plus4_f;
  logic [31:0] w_pc_next;
  logic        w_resolve;
  logic        w_mis_nt;
  logic        w_mis_t;
  logic        w_mis_alias;
  logic        w_mispredict;
  logic        w_flush_d;
  logic        w_pipe_en;

  // A branch is only resolved while D is advancing; a stalled D has no
  // decision to make yet.
  assign w_pc_plus4_f = r_pc_f + 32'd4;
  assign w_resolve    = branch_d & ~stall_d;
  assign w_mis_nt     = w_resolve & r_pred_d & ~branch_taken_d;
  assign w_mis_t      = w_resolve & branch_taken_d &
                        (~r_pred_d | (r_pred_target_d != pc_branch_d));
  assign w_mis_alias  = ~stall_d & ~branch_d & r_pred_d;
  assign w_mispredict = w_mis_nt | w_mis_t | w_mis_alias;
  assign w_flush_d    = exc_req | w_mispredict;
  assign w_pipe_en    = ~stall_d | w_flush_d;

  // Next-PC selection: exceptions and redirects win over a fetch stall.
  always_comb begin
    w_pc_next = w_pc_plus4_f;
    if (exc_req)
      w_pc_next = EXC_VECTOR;
    else if (w_mis_t)
      w_pc_next = pc_branch_d;
    else if (w_mis_nt | w_mis_alias)
      w_pc_next = r_pc_plus4_d;
    else if (stall_f)
      w_pc_next = r_pc_f;
    else if (predictor_sel)
      w_pc_next = predictor_target;
  end

  // PC_F register, which loads the selected next PC on every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_pc_f <= RESET_VECTOR;
    else
      r_pc_f <= w_pc_next;
  end

  // F->D prediction pipe. A flush kills the prediction so that the
  // instruction fetched from the redirect target is not judged by it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pred_d        <= 1'b0;
      r_pred_target_d <= 32'd0;
      r_pc_plus4_d    <= RESET_VECTOR + 32'd4;
    end else if (w_pipe_en) begin
      r_pred_d        <= w_flush_d ? 1'b0 : predictor_sel;
      r_pred_target_d <= predictor_target;
      r_pc_plus4_d    <= w_pc_plus4_f;
    end
  end

  // Statistics counters. They saturate at all-ones and a clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (cnt_clr) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_resolve && (r_branch_cnt != {CNT_W{1'b1}}))
        r_branch_cnt <= r_branch_cnt + 1'b1;
      if (w_mispredict && (r_mispred_cnt != {CNT_W{1'b1}}))
        r_mispred_cnt <= r_mispred_cnt + 1'b1;
    end
  end

  assign pc_f        = r_pc_f;
  assign pc_plus4_f  = w_pc_plus4_f;
  assign flush_d     = w_flush_d;
  assign mispredict  = w_mispredict;
  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit.
// Expected values are queued when stimulus is driven. Combinational ones are
// checked shortly after the inputs settle, and registered ones just after the
// following rising edge.
module tb_fetch_pc_unit;

  localparam int CNT_W = 16;

  localparam int K_PC    = 0;
  localparam int K_PC4   = 1;
  localparam int K_FLUSH = 2;
  localparam int K_MISP  = 3;
  localparam int K_BCNT  = 4;
  localparam int K_MCNT  = 5;

  typedef struct {
    int          kind;
    logic [31:0] value;
  } expItem_t;

  logic             clk;
  logic             rst;
  logic             stall_f;
  logic             stall_d;
  logic             exc_req;
  logic             predictor_sel;
  logic [31:0]      predictor_target;
  logic             branch_d;
  logic             branch_taken_d;
  logic [31:0]      pc_branch_d;
  logic             cnt_clr;
  logic [31:0]      pc_f;
  logic [31:0]      pc_plus4_f;
  logic             flush_d;
  logic             mispredict;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  expItem_t combQ[$];
  expItem_t regQ[$];
  int       assertCount;
  int       failCount;

  fetch_pc_unit #(
    .RESET_VECTOR(32'h0000_0000),
    .EXC_VECTOR  (32'h8000_0180),
    .CNT_W       (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_f         (stall_f),
    .stall_d         (stall_d),
    .exc_req         (exc_req),
    .predictor_sel   (predictor_sel),
    .predictor_target(predictor_target),
    .branch_d        (branch_d),
    .branch_taken_d  (branch_taken_d),
    .pc_branch_d     (pc_branch_d),
    .cnt_clr         (cnt_clr),
    .pc_f            (pc_f),
    .pc_plus4_f      (pc_plus4_f),
    .flush_d         (flush_d),
    .mispredict      (mispredict),
    .branch_cnt      (branch_cnt),
    .mispred_cnt     (mispred_cnt)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic string kindName(input int kind);
    case (kind)
      K_PC:    return "pc_f";
      K_PC4:   return "pc_plus4_f";
      K_FLUSH: return "flush_d";
      K_MISP:  return "mispredict";
      K_BCNT:  return "branch_cnt";
      K_MCNT:  return "mispred_cnt";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_PC:    return pc_f;
      K_PC4:   return pc_plus4_f;
      K_FLUSH: return {31'd0, flush_d};
      K_MISP:  return {31'd0, mispredict};
      K_BCNT:  return {{(32-CNT_W){1'b0}}, branch_cnt};
      K_MCNT:  return {{(32-CNT_W){1'b0}}, mispred_cnt};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h at t=%0t",
               tag, observed, expected, $time);
    end
  endtask

  task automatic expectComb(input int kind, input logic [31:0] value);
    expItem_t item;
    item.kind  = kind;
    item.value = value;
    combQ.push_back(item);
  endtask

  task automatic expectReg(input int kind, input logic [31:0] value);
    expItem_t item;
    item.kind  = kind;
    item.value = value;
    regQ.push_back(item);
  endtask

  task automatic drainComb();
    expItem_t item;
    while (combQ.size() > 0) begin
      item = combQ.pop_front();
      checkOutput({"comb ", kindName(item.kind)}, observe(item.kind), item.value);
    end
  endtask

  task automatic drainReg();
    expItem_t item;
    while (regQ.size() > 0) begin
      item = regQ.pop_front();
      checkOutput({"reg ", kindName(item.kind)}, observe(item.kind), item.value);
    end
  endtask

  // One cycle: check settled combinational outputs, take the edge, check
  // registered outputs, then return to the falling edge for the next drive.
  task automatic applyStimulus();
    #1;
    drainComb();
    @(posedge clk);
    #1;
    drainReg();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    stall_f          = 1'b0;
    stall_d          = 1'b0;
    exc_req          = 1'b0;
    predictor_sel    = 1'b0;
    predictor_target = 32'd0;
    branch_d         = 1'b0;
    branch_taken_d   = 1'b0;
    pc_branch_d      = 32'd0;
    cnt_clr          = 1'b0;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst         = 1'b1;
    idleInputs();

    // Reset state.
    repeat (2) @(negedge clk);
    expectComb(K_PC, 32'h0);
    expectComb(K_PC4, 32'h4);
    expectComb(K_FLUSH, 32'h0);
    expectComb(K_MISP, 32'h0);
    expectComb(K_BCNT, 32'h0);
    expectComb(K_MCNT, 32'h0);
    #1;
    drainComb();
    rst = 1'b0;

    // Sequential fetch from 0x0 to 0x10.
    for (int i = 1; i <= 4; i++) begin
      expectComb(K_FLUSH, 32'h0);
      expectReg(K_PC, i * 4);
      applyStimulus();
    end

    // Correct taken prediction at 0x10 to 0x40 gives no bubble.
    predictor_sel    = 1'b1;
    predictor_target = 32'h40;
    expectComb(K_MISP, 32'h0);
    expectReg(K_PC, 32'h40);
    applyStimulus();
    predictor_sel    = 1'b0;
    branch_d         = 1'b1;
    branch_taken_d   = 1'b1;
    pc_branch_d      = 32'h40;
    expectComb(K_MISP, 32'h0);
    expectComb(K_FLUSH, 32'h0);
    expectReg(K_PC, 32'h44);
    expectReg(K_BCNT, 32'h1);
    expectReg(K_MCNT, 32'h0);
    applyStimulus();
    idleInputs();

    // Mid-stream reset, then free run up to 0x20.
    rst = 1'b1;
    expectComb(K_PC, 32'h0);
    expectComb(K_BCNT, 32'h0);
    #1;
    drainComb();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      expectReg(K_PC, i * 4);
      applyStimulus();
    end

    // Predicted taken at 0x20 but not taken in D, so redirect to 0x24.
    predictor_sel    = 1'b1;
    predictor_target = 32'h80;
    expectReg(K_PC, 32'h80);
    applyStimulus();
    predictor_sel    = 1'b0;
    branch_d         = 1'b1;
    branch_taken_d   = 1'b0;
    expectComb(K_MISP, 32'h1);
    expectComb(K_FLUSH, 32'h1);
    expectReg(K_PC, 32'h24);
    expectReg(K_MCNT, 32'h1);
    expectReg(K_BCNT, 32'h1);
    applyStimulus();
    idleInputs();

    // Free run 0x24 to 0x30, then fetch 0x30 without a prediction.
    for (int i = 1; i <= 4; i++) begin
      expectReg(K_PC, 32'h24 + i * 4);
      applyStimulus();
    end
    // The taken branch to 0x100 is held in D by a stall for two cycles.
    branch_d       = 1'b1;
    branch_taken_d = 1'b1;
    pc_branch_d    = 32'h100;
    stall_d        = 1'b1;
    stall_f        = 1'b1;
    for (int i = 0; i < 2; i++) begin
      expectComb(K_MISP, 32'h0);
      expectComb(K_FLUSH, 32'h0);
      expectReg(K_PC, 32'h34);
      expectReg(K_BCNT, 32'h1);
      applyStimulus();
    end
    stall_d = 1'b0;
    stall_f = 1'b0;
    expectComb(K_MISP, 32'h1);
    expectComb(K_FLUSH, 32'h1);
    expectReg(K_PC, 32'h100);
    expectReg(K_BCNT, 32'h2);
    expectReg(K_MCNT, 32'h2);
    applyStimulus();

    // An exception together with a taken mispredict under stall_f goes to the vector.
    pc_branch_d = 32'h200;
    stall_f     = 1'b1;
    exc_req     = 1'b1;
    expectComb(K_MISP, 32'h1);
    expectComb(K_FLUSH, 32'h1);
    expectReg(K_PC, 32'h8000_0180);
    expectReg(K_MCNT, 32'h3);
    expectReg(K_BCNT, 32'h3);
    applyStimulus();
    idleInputs();

    // Unaligned redirect: the low bits pass through.
    branch_d       = 1'b1;
    branch_taken_d = 1'b1;
    pc_branch_d    = 32'h103;
    expectReg(K_PC, 32'h103);
    applyStimulus();
    branch_d = 1'b0;
    expectComb(K_PC4, 32'h107);
    expectComb(K_MISP, 32'h0);
    expectReg(K_PC, 32'h107);
    applyStimulus();

    // Wraparound: redirect to 0xFFFF_FFFC, then +4 wraps to 0.
    branch_d    = 1'b1;
    pc_branch_d = 32'hFFFF_FFFC;
    expectReg(K_PC, 32'hFFFF_FFFC);
    expectReg(K_MCNT, 32'h5);
    applyStimulus();
    branch_d = 1'b0;
    expectComb(K_PC4, 32'h0);
    expectReg(K_PC, 32'h0);
    applyStimulus();

    // Saturation: a mispredict on every cycle drives the counter up to 0xFFFF.
    branch_d       = 1'b1;
    branch_taken_d = 1'b1;
    pc_branch_d    = 32'h300;
    repeat (65529) @(posedge clk);
    @(negedge clk);
    expectComb(K_MISP, 32'h1);
    expectReg(K_MCNT, 32'hFFFF);
    expectReg(K_BCNT, 32'hFFFF);
    applyStimulus();
    for (int i = 0; i < 2; i++) begin
      expectComb(K_MISP, 32'h1);
      expectReg(K_MCNT, 32'hFFFF);
      applyStimulus();
    end
    // A clear during a mispredict wins over the increment.
    cnt_clr = 1'b1;
    expectComb(K_MISP, 32'h1);
    expectReg(K_MCNT, 32'h0);
    expectReg(K_BCNT, 32'h0);
    applyStimulus();
    cnt_clr = 1'b0;
    expectReg(K_MCNT, 32'h1);
    expectReg(K_BCNT, 32'h1);
    applyStimulus();
    idleInputs();

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
